// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Handshake bundle between the five-stage pipeline and its
//                control unit. The pipeline side (master) raises stall
//                requests and MEM-stage exception reports. The control side
//                (slave) returns the per-stage freeze vector, the flush
//                strobe with its redirect address, and the perf counters.
//  Signals     : stallreq_id/ex/mem  - stall requests from ID, EX and MEM
//                excepttype_i        - MEM exception code (0 none, 0xE ERET)
//                cp0_epc_i           - CP0 EPC, the return target of ERET
//                stall[5:0]          - freeze vector (bit0 PC .. bit4 MEM/WB)
//                flush, new_pc       - pipeline clear and redirect target
//                stall_cycles_o      - saturating count of stalled cycles
//                flush_count_o       - wrapping count of flushes
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, stall_cycles_o, flush_count_o
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, stall_cycles_o, flush_count_o
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline control unit for the five-stage MIPS32 core.
//                Merges stall requests into a prioritised freeze vector and
//                turns MEM-stage exception / ERET reports into a one-cycle
//                flush with a redirect address. After a flush, a drain window
//                of DRAIN_CYCLES cycles masks further exceptions and the
//                ID/EX stall requests. Counts stalled cycles and flushes.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous, active-low reset
//                bus  - pipe_ctrl_if.slave (requests in, stall/flush out)
//  Parameters  : EXC_VECTOR   - redirect target for non-ERET exceptions
//                DRAIN_CYCLES - post-flush masking window, 0..3
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_1180,
    parameter int unsigned DRAIN_CYCLES = 1
) (
    input wire         clk,
    input wire         rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [31:0] c_ERET_CODE  = 32'h0000_000e;
    localparam bit          c_HAS_DRAIN  = (DRAIN_CYCLES > 0);
    // Drain counter load value: the window ends when the counter reads 0.
    localparam logic [1:0]  c_DRAIN_LOAD = c_HAS_DRAIN ? 2'(DRAIN_CYCLES - 1) : 2'd0;

    localparam logic [5:0]  c_STALL_MEM  = 6'b011111;
    localparam logic [5:0]  c_STALL_EX   = 6'b001111;
    localparam logic [5:0]  c_STALL_ID   = 6'b000111;
    localparam logic [5:0]  c_STALL_NONE = 6'b000000;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_dcnt;
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    logic        w_in_run;
    logic        w_exc;
    logic        w_flush;
    logic [31:0] w_new_pc;
    logic [5:0]  w_stall;

    // ------------------------------------------------------------------------
    // Combinational outputs. All three are gated by rst so they drop the
    // moment reset is asserted, without waiting for the state to clear.
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_run = (r_state == ST_RUN);
        w_exc    = w_in_run && (bus.excepttype_i != 32'd0);
        w_flush  = rst && w_exc;

        w_new_pc = 32'd0;
        if (w_flush) begin
            w_new_pc = (bus.excepttype_i == c_ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
        end

        // A flush clears every stage, so it overrides any freeze request.
        // During the drain window only the MEM request is still honoured.
        w_stall = c_STALL_NONE;
        if (!rst || w_exc) begin
            w_stall = c_STALL_NONE;
        end else if (bus.stallreq_mem) begin
            w_stall = c_STALL_MEM;
        end else if (w_in_run && bus.stallreq_ex) begin
            w_stall = c_STALL_EX;
        end else if (w_in_run && bus.stallreq_id) begin
            w_stall = c_STALL_ID;
        end
    end

    // ------------------------------------------------------------------------
    // State machine and performance counters.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_RUN;
            r_dcnt         <= 2'd0;
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_exc) begin
                        r_flush_count <= r_flush_count + 16'd1;
                        if (c_HAS_DRAIN) begin
                            r_state <= ST_DRAIN;
                            r_dcnt  <= c_DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_dcnt == 2'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_dcnt <= r_dcnt - 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_dcnt  <= 2'd0;
                end
            endcase

            // Saturating: once all ones, the count is pinned there.
            if ((w_stall != c_STALL_NONE) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign bus.stall          = w_stall;
    assign bus.flush          = w_flush;
    assign bus.new_pc         = w_new_pc;
    assign bus.stall_cycles_o = r_stall_cycles;
    assign bus.flush_count_o  = r_flush_count;

endmodule
`default_nettype wire
